// File: rtl/ee354_param_numlock_if.sv
// Button inputs and status outputs of the parametrised number lock.
// The master side drives the raw buttons; the slave side is the lock itself.
interface ee354_param_numlock_if;
  logic       U;
  logic       Z;
  logic       unlock;
  logic [2:0] state_code;
  logic [3:0] digit_idx;
  logic [3:0] fail_cnt;
  logic       locked_out;
  logic       blink;

  modport master (
    output U, Z,
    input  unlock, state_code, digit_idx, fail_cnt, locked_out, blink
  );

  modport slave (
    input  U, Z,
    output unlock, state_code, digit_idx, fail_cnt, locked_out, blink
  );
endinterface

// File: rtl/ee354_param_numlock.sv
// Serial-code number lock: synchronised U/Z buttons, timed OPENING, optional failure lockout.
// NUMLOCK_LOCKOUT_EN enables fail counting and the LOCKOUT state; undefined ties them off.
module ee354_param_numlock #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  OPEN_CYCLES    = 100000000,
  parameter int                  LOCKOUT_CYCLES = 500000000,
  parameter int                  BLINK_BIT      = 24
) (
  input  logic                   ClkPort,
  input  logic                   reset,
  ee354_param_numlock_if.slave   nl
);

`ifdef NUMLOCK_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  localparam logic [3:0]  CODE_LEN_W  = 4'(CODE_LEN);
  localparam logic [3:0]  MAX_FAIL_W  = 4'(MAX_FAIL);
  localparam logic [31:0] OPEN_LAST   = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LAST = 32'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REL = 3'd1,
    ENTER    = 3'd2,
    OPENING  = 3'd3,
    BAD      = 3'd4,
    LOCKOUT  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [3:0]  digit_r, digit_nxt;
  logic [3:0]  fail_r, fail_nxt, fail_inc;

  // Button synchronisers preset to 1 so a button held through reset is not a press.
  logic u_s1, u_s2, u_p;
  logic z_s1, z_s2, z_p;

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      u_s1 <= 1'b1;
      u_s2 <= 1'b1;
      u_p  <= 1'b1;
      z_s1 <= 1'b1;
      z_s2 <= 1'b1;
      z_p  <= 1'b1;
    end else begin
      u_s1 <= nl.U;
      u_s2 <= u_s1;
      u_p  <= u_s2;
      z_s1 <= nl.Z;
      z_s2 <= z_s1;
      z_p  <= z_s2;
    end
  end

  logic u_ev, z_ev, any_press, released;
  logic exp_bit, correct;

  assign u_ev      = u_s2 & ~u_p;
  assign z_ev      = z_s2 & ~z_p;
  assign any_press = u_ev | z_ev;
  assign released  = ~u_s2 & ~z_s2;

  // Digit expected at the current position; the MSB of CODE is entered first.
  always_comb begin
    exp_bit = 1'b0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_r == 4'(CODE_LEN - 1 - i))
        exp_bit = CODE[i];
    end
  end

  assign correct  = (u_ev ^ z_ev) & (u_ev ? exp_bit : ~exp_bit);
  assign fail_inc = !LOCKOUT_EN          ? 4'd0   :
                    (fail_r == MAX_FAIL_W) ? fail_r : fail_r + 4'd1;

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      digit_r <= '0;
      fail_r  <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      digit_r <= digit_nxt;
      fail_r  <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    digit_nxt = digit_r;
    fail_nxt  = fail_r;
    case (state)
      IDLE, ENTER: begin
        if (correct) begin
          digit_nxt = digit_r + 4'd1;
          state_nxt = WAIT_REL;
        end else if (any_press) begin
          digit_nxt = '0;
          fail_nxt  = fail_inc;
          state_nxt = BAD;
        end
      end
      WAIT_REL: begin
        if (released)
          state_nxt = (digit_r == CODE_LEN_W) ? OPENING : ENTER;
      end
      OPENING: begin
        if (timer == OPEN_LAST) begin
          state_nxt = IDLE;
          digit_nxt = '0;
          fail_nxt  = '0;
        end
      end
      BAD: begin
        if (released)
          state_nxt = (LOCKOUT_EN && fail_r == MAX_FAIL_W) ? LOCKOUT : IDLE;
      end
      LOCKOUT: begin
        if (!LOCKOUT_EN || timer == LOCKOUT_LAST) begin
          state_nxt = IDLE;
          fail_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        digit_nxt = '0;
        fail_nxt  = '0;
      end
    endcase
    timer_nxt = (state_nxt != state) ? 32'd0 : timer + 32'd1;
  end

  always_comb begin
    nl.unlock     = (state == OPENING);
    nl.state_code = state;
    nl.digit_idx  = digit_r;
    nl.fail_cnt   = LOCKOUT_EN ? fail_r : 4'd0;
    nl.locked_out = LOCKOUT_EN && (state == LOCKOUT);
    nl.blink      = (state == OPENING) ? timer[BLINK_BIT] : 1'b0;
  end

endmodule

// File: tb/tb_ee354_param_numlock.sv
// Directed bench for ee354_param_numlock with short OPEN/LOCKOUT times.
// Expectations follow NUMLOCK_LOCKOUT_EN as seen by this compilation.
module tb_ee354_param_numlock;

`ifdef NUMLOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ee354_param_numlock_if nl_if ();

  ee354_param_numlock #(
    .CODE_LEN       (4),
    .CODE           (4'b1011),
    .MAX_FAIL       (3),
    .OPEN_CYCLES    (16),
    .LOCKOUT_CYCLES (32),
    .BLINK_BIT      (1)
  ) dut (
    .ClkPort (clk),
    .reset   (reset),
    .nl      (nl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    nl_if.U = 1'b0;
    nl_if.Z = 1'b0;
    wait_neg(2);
    reset = 1'b0;
    wait_neg(4);
  endtask

  // Press or release takes three negedges to show in the state registers.
  task automatic set_btn(input logic u, input logic z);
    nl_if.U = u;
    nl_if.Z = z;
    wait_neg(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    nl_if.U = 1'b0;
    nl_if.Z = 1'b0;
    wait_neg(2);
    total++;
    if ({nl_if.unlock, nl_if.state_code, nl_if.digit_idx, nl_if.fail_cnt, nl_if.locked_out, nl_if.blink} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want all zero",
               {nl_if.unlock, nl_if.state_code, nl_if.digit_idx, nl_if.fail_cnt, nl_if.locked_out, nl_if.blink});
    end
    reset = 1'b0;
    wait_neg(4);
    total++;
    if (nl_if.state_code !== 3'd0) begin
      bad++;
      $display("FAIL reset_idle: got %0d want 0", nl_if.state_code);
    end
  endtask

  task automatic test_correct_entry();
    logic [3:0] seq;
    int cnt;
    seq = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      set_btn(seq[3-i], ~seq[3-i]);
      total++;
      if (nl_if.digit_idx !== 4'(i + 1) || nl_if.state_code !== 3'd1) begin
        bad++;
        $display("FAIL entry_digit%0d: got idx=%0d st=%0d want idx=%0d st=1",
                 i, nl_if.digit_idx, nl_if.state_code, i + 1);
      end
      set_btn(1'b0, 1'b0);
    end
    cnt = 0;
    while (nl_if.unlock === 1'b1 && cnt < 100) begin
      total++;
      if (nl_if.blink !== 1'(cnt >> 1)) begin
        bad++;
        $display("FAIL blink_at_%0d: got %b want %b", cnt, nl_if.blink, 1'(cnt >> 1));
      end
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt !== 16) begin
      bad++;
      $display("FAIL unlock_len: got %0d want 16", cnt);
    end
    total++;
    if (nl_if.state_code !== 3'd0 || nl_if.fail_cnt !== 4'd0 || nl_if.digit_idx !== 4'd0) begin
      bad++;
      $display("FAIL after_open: got st=%0d fail=%0d idx=%0d want 0/0/0",
               nl_if.state_code, nl_if.fail_cnt, nl_if.digit_idx);
    end
  endtask

  task automatic test_wrong_digit();
    do_reset();
    set_btn(1'b1, 1'b0);
    set_btn(1'b0, 1'b0);
    set_btn(1'b0, 1'b1);
    set_btn(1'b0, 1'b0);
    set_btn(1'b0, 1'b1);
    total++;
    if (nl_if.state_code !== 3'd4 || nl_if.fail_cnt !== (LOCK_EN ? 4'd1 : 4'd0) || nl_if.digit_idx !== 4'd0) begin
      bad++;
      $display("FAIL wrong_digit: got st=%0d fail=%0d idx=%0d want st=4 fail=%0d idx=0",
               nl_if.state_code, nl_if.fail_cnt, nl_if.digit_idx, LOCK_EN ? 1 : 0);
    end
    set_btn(1'b0, 1'b0);
    total++;
    if (nl_if.state_code !== 3'd0) begin
      bad++;
      $display("FAIL wrong_release: got st=%0d want 0", nl_if.state_code);
    end
  endtask

`ifdef NUMLOCK_LOCKOUT_EN
  task automatic test_lockout();
    int cnt;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_btn(1'b0, 1'b1);
      total++;
      if (nl_if.state_code !== 3'd4 || nl_if.fail_cnt !== 4'(i)) begin
        bad++;
        $display("FAIL lock_press%0d: got st=%0d fail=%0d want st=4 fail=%0d",
                 i, nl_if.state_code, nl_if.fail_cnt, i);
      end
      set_btn(1'b0, 1'b0);
    end
    cnt = 0;
    while (nl_if.locked_out === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 5) nl_if.U = 1'b1;
      if (cnt == 12) nl_if.U = 1'b0;
      if (cnt == 20) begin
        total++;
        if (nl_if.state_code !== 3'd5 || nl_if.digit_idx !== 4'd0) begin
          bad++;
          $display("FAIL lock_ignore: got st=%0d idx=%0d want st=5 idx=0",
                   nl_if.state_code, nl_if.digit_idx);
        end
      end
      @(negedge clk);
    end
    total++;
    if (cnt !== 32) begin
      bad++;
      $display("FAIL lock_len: got %0d want 32", cnt);
    end
    total++;
    if (nl_if.state_code !== 3'd0 || nl_if.fail_cnt !== 4'd0) begin
      bad++;
      $display("FAIL lock_exit: got st=%0d fail=%0d want 0/0", nl_if.state_code, nl_if.fail_cnt);
    end
  endtask
`else
  task automatic test_no_lockout();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_btn(1'b0, 1'b1);
      total++;
      if (nl_if.state_code !== 3'd4 || nl_if.fail_cnt !== 4'd0) begin
        bad++;
        $display("FAIL nolock_press%0d: got st=%0d fail=%0d want st=4 fail=0",
                 i, nl_if.state_code, nl_if.fail_cnt);
      end
      set_btn(1'b0, 1'b0);
      total++;
      if (nl_if.state_code !== 3'd0 || nl_if.locked_out !== 1'b0) begin
        bad++;
        $display("FAIL nolock_release%0d: got st=%0d lo=%b want st=0 lo=0",
                 i, nl_if.state_code, nl_if.locked_out);
      end
    end
  endtask
`endif

  task automatic test_simultaneous();
    do_reset();
    set_btn(1'b1, 1'b1);
    total++;
    if (nl_if.state_code !== 3'd4 || nl_if.fail_cnt !== (LOCK_EN ? 4'd1 : 4'd0)) begin
      bad++;
      $display("FAIL simul_bad: got st=%0d fail=%0d want st=4 fail=%0d",
               nl_if.state_code, nl_if.fail_cnt, LOCK_EN ? 1 : 0);
    end
    set_btn(1'b0, 1'b0);
    set_btn(1'b1, 1'b0);
    set_btn(1'b1, 1'b1);
    total++;
    if (nl_if.state_code !== 3'd1 || nl_if.digit_idx !== 4'd1) begin
      bad++;
      $display("FAIL waitrel_ignore: got st=%0d idx=%0d want st=1 idx=1",
               nl_if.state_code, nl_if.digit_idx);
    end
    set_btn(1'b1, 1'b0);
    total++;
    if (nl_if.state_code !== 3'd1) begin
      bad++;
      $display("FAIL waitrel_held: got st=%0d want 1", nl_if.state_code);
    end
    set_btn(1'b0, 1'b0);
    total++;
    if (nl_if.state_code !== 3'd2 || nl_if.digit_idx !== 4'd1) begin
      bad++;
      $display("FAIL waitrel_exit: got st=%0d idx=%0d want st=2 idx=1",
               nl_if.state_code, nl_if.digit_idx);
    end
  endtask

  task automatic test_reset_mid_entry();
    do_reset();
    set_btn(1'b1, 1'b0);
    set_btn(1'b0, 1'b0);
    set_btn(1'b0, 1'b1);
    set_btn(1'b0, 1'b0);
    total++;
    if (nl_if.digit_idx !== 4'd2 || nl_if.state_code !== 3'd2) begin
      bad++;
      $display("FAIL mid_setup: got idx=%0d st=%0d want idx=2 st=2", nl_if.digit_idx, nl_if.state_code);
    end
    nl_if.U = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({nl_if.unlock, nl_if.state_code, nl_if.digit_idx, nl_if.fail_cnt, nl_if.locked_out, nl_if.blink} !== 14'd0) begin
      bad++;
      $display("FAIL async_reset: got %b want all zero",
               {nl_if.unlock, nl_if.state_code, nl_if.digit_idx, nl_if.fail_cnt, nl_if.locked_out, nl_if.blink});
    end
    wait_neg(2);
    reset = 1'b0;
    wait_neg(5);
    total++;
    if (nl_if.state_code !== 3'd0 || nl_if.digit_idx !== 4'd0) begin
      bad++;
      $display("FAIL held_no_press: got st=%0d idx=%0d want 0/0", nl_if.state_code, nl_if.digit_idx);
    end
    set_btn(1'b0, 1'b0);
    set_btn(1'b1, 1'b0);
    total++;
    if (nl_if.state_code !== 3'd1 || nl_if.digit_idx !== 4'd1) begin
      bad++;
      $display("FAIL repress: got st=%0d idx=%0d want st=1 idx=1", nl_if.state_code, nl_if.digit_idx);
    end
    set_btn(1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_correct_entry();
    test_wrong_digit();
`ifdef NUMLOCK_LOCKOUT_EN
    test_lockout();
`else
    test_no_lockout();
`endif
    test_simultaneous();
    test_reset_mid_entry();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ee354_param_numlock.md
# ee354_param_numlock

Parametrised successor to the fixed 1011 number lock. It accepts a CODE_LEN-bit code entered serially on two buttons (U = 1, Z = 0) and synchronises and edge-detects the raw buttons internally. It holds the unlock output for a programmable time and, optionally, locks out entry after repeated failures. It sits between the board button inputs and the LED/SSD display logic of the top level.

## Interface
- CODE_LEN, 4: number of code digits, 1..15.
- CODE, 4'b1011: code value, CODE_LEN bits; MSB is entered first.
- MAX_FAIL, 3: consecutive failures that trigger lockout, 1..15.
- OPEN_CYCLES, 100000000: ClkPort cycles spent in OPENING, at least 2.
- LOCKOUT_CYCLES, 500000000: ClkPort cycles spent in LOCKOUT, at least 2.
- BLINK_BIT, 24: timer bit that drives blink during OPENING.
- ClkPort, in, 1: system clock.
- reset, in, 1: asynchronous, active-high; clock is ClkPort.
- U, in, 1: raw "1" button, asynchronous.
- Z, in, 1: raw "0" button, asynchronous.
- unlock, out, 1: high only in OPENING.
- state_code, out, 3: IDLE=0, WAIT_REL=1, ENTER=2, OPENING=3, BAD=4, LOCKOUT=5.
- digit_idx, out, 4: number of correct digits accepted so far.
- fail_cnt, out, 4: consecutive failure count.
- locked_out, out, 1: high only in LOCKOUT.
- blink, out, 1: equals timer[BLINK_BIT] in OPENING; 0 otherwise.

## Operation
- Inputs
  - U and Z each pass through two flops (s1, s2), then a previous-value flop (p).
  - A press event is s2 & ~p.
  - Released means s2_U == 0 and s2_Z == 0.
  - s1, s2 and p reset to 1, so a button held through reset is not counted as a press.
- Digit check: a press is correct when exactly one of U/Z has an event this cycle and its value equals CODE[CODE_LEN-1-digit_idx]. Simultaneous U and Z events count as an incorrect press.
- FSM transitions:
  - IDLE or ENTER, correct press: digit_idx+1, go to WAIT_REL.
  - IDLE or ENTER, incorrect press: go to BAD; fail_cnt+1, saturating at MAX_FAIL.
  - WAIT_REL: new presses are ignored. Once released, go to OPENING if digit_idx==CODE_LEN, else ENTER.
  - OPENING: timer counts from 0. When timer==OPEN_CYCLES-1, go to IDLE and clear digit_idx and fail_cnt.
  - BAD: presses are ignored and digit_idx is cleared on entry. Once released, go to LOCKOUT if fail_cnt==MAX_FAIL, else IDLE.
  - LOCKOUT: presses are ignored. When timer==LOCKOUT_CYCLES-1, go to IDLE and clear fail_cnt.
- Timer: 32-bit, cleared on every state change, counts otherwise.
- Reset: state IDLE, all counters 0, timer 0.
- Output reset values: unlock=0, state_code=0, digit_idx=0, fail_cnt=0, locked_out=0, blink=0.
- Reset mid-operation aborts immediately; no partial code is retained.

## Timing
- If a button rises before edge k, the press event is true between edges k+1 and k+2, and the state/counter update is visible after edge k+2.
- Release detection has the same 2-edge latency.
- All outputs are decoded from registers only, with no combinational path from U or Z.
- OPENING and LOCKOUT each last exactly OPEN_CYCLES and LOCKOUT_CYCLES cycles.
- A press event arriving on the cycle an OPENING or LOCKOUT timeout fires is ignored.

## Configuration
- NUMLOCK_LOCKOUT_EN defined: fail_cnt, MAX_FAIL and the LOCKOUT state behave as specified above.
- NUMLOCK_LOCKOUT_EN undefined:
  - fail_cnt is tied to 0 and locked_out to 0.
  - BAD always returns to IDLE on release.
  - LOCKOUT is unreachable; state_code never equals 5.

## Test plan
Bench settings: CODE_LEN=4, CODE=1011, MAX_FAIL=3, OPEN_CYCLES=16, LOCKOUT_CYCLES=32, BLINK_BIT=1, NUMLOCK_LOCKOUT_EN defined.
- Correct entry: press/release U, Z, U, U.
  - digit_idx steps 1,2,3,4.
  - unlock is high for exactly 16 cycles and blink toggles every 2 cycles.
  - Then state_code=0 and fail_cnt=0.
- Wrong digit: press U, Z, Z.
  - On the 3rd press, state_code=4, fail_cnt=1, digit_idx=0.
  - After release, state_code=0.
- Lockout: three wrong first presses (Z).
  - fail_cnt reaches 3 and locked_out is high for 32 cycles.
  - A U press during lockout has no effect.
  - Afterwards fail_cnt=0.
- Simultaneous press: U and Z rise on the same cycle in IDLE.
  - Result is BAD, fail_cnt=1.
  - A second press while U is still held is ignored in WAIT_REL.
- Reset: assert reset mid-entry (digit_idx=2) while U is held.
  - All outputs go to 0 asynchronously.
  - After reset deasserts, holding U produces no press; a release then press of U gives digit_idx=1.
- Macro undefined: four consecutive wrong presses.
  - fail_cnt stays 0 and state_code never equals 5.
